// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle control unit for the single-issue datapath.
//
// Sequences IF -> ID -> EXE -> MEM -> WB. The fetched instruction is latched
// into an internal IR when leaving IF. All control outputs are combinational
// from the current state and the latched IR.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset (forces all controls low this cycle)
//   instr      instruction-memory read data, valid during IF
//   zero       ALU zero flag, consumed by beq in EXE
//   PcWrite    PC load enable
//   PcSrc      00 = PC+4, 01 = branch target, 10 = jump target
//   IrWrite    datapath IR load enable (IF only)
//   RegWrite   register-file write enable (WB only)
//   RegDst     1 = rd, 0 = rt
//   MemWrite   data-memory write enable (final MEM cycle of sw)
//   MemToReg   1 = writeback from memory, 0 = from ALU
//   ExtSel     1 = sign-extend imm16, 0 = zero-extend
//   Alu_SrcA   1 = shamt, 0 = ReadData1
//   Alu_SrcB   1 = extended immediate, 0 = ReadData2
//   Alu_Op     ALU operation code
//   state      current state, for debug
//   illegal_op one-cycle pulse in ID for an unsupported opcode/funct
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PcWrite,
  output logic [1:0]  PcSrc,
  output logic        IrWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ExtSel,
  output logic        Alu_SrcA,
  output logic        Alu_SrcB,
  output logic [3:0]  Alu_Op,
  output logic [2:0]  state,
  output logic        illegal_op
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;

  // Decoded fields of the latched instruction
  logic [5:0] op_s, funct_s;
  logic [3:0] dec_op_s;
  logic       dec_srca_s, dec_srcb_s, dec_ext_s;
  logic       is_r_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, legal_s;

  // Register fields are consumed by the datapath, not by control
  logic unused_ir_s;
  assign unused_ir_s = ^ir_q[25:6];

  assign op_s    = ir_q[31:26];
  assign funct_s = ir_q[5:0];

  // Instruction decode: ALU op, operand sources and instruction class
  always_comb begin
    dec_op_s   = 4'd0;
    dec_srca_s = 1'b0;
    dec_srcb_s = 1'b0;
    dec_ext_s  = 1'b0;
    is_r_s     = 1'b0;
    is_lw_s    = 1'b0;
    is_sw_s    = 1'b0;
    is_beq_s   = 1'b0;
    is_j_s     = 1'b0;
    legal_s    = 1'b1;
    case (op_s)
      6'b000000: begin
        is_r_s = 1'b1;
        case (funct_s)
          6'b100000, 6'b100001: dec_op_s = 4'b0001;
          6'b100010, 6'b100011: dec_op_s = 4'b0010;
          6'b101010:            dec_op_s = 4'b0011;
          6'b100100:            dec_op_s = 4'b0100;
          6'b100111:            dec_op_s = 4'b0101;
          6'b100101:            dec_op_s = 4'b0110;
          6'b100110:            dec_op_s = 4'b0111;
          6'b000000: begin dec_op_s = 4'b1000; dec_srca_s = 1'b1; end
          6'b000010: begin dec_op_s = 4'b1001; dec_srca_s = 1'b1; end
          default: begin
            is_r_s  = 1'b0;
            legal_s = 1'b0;
          end
        endcase
      end
      6'b001001: begin dec_op_s = 4'b0001; dec_srcb_s = 1'b1; dec_ext_s = 1'b1; end
      6'b001010: begin dec_op_s = 4'b0011; dec_srcb_s = 1'b1; dec_ext_s = 1'b1; end
      6'b001100: begin dec_op_s = 4'b0100; dec_srcb_s = 1'b1; end
      6'b001101: begin dec_op_s = 4'b0110; dec_srcb_s = 1'b1; end
      6'b001110: begin dec_op_s = 4'b0111; dec_srcb_s = 1'b1; end
      6'b100011: begin dec_op_s = 4'b0001; dec_srcb_s = 1'b1; dec_ext_s = 1'b1; is_lw_s = 1'b1; end
      6'b101011: begin dec_op_s = 4'b0001; dec_srcb_s = 1'b1; dec_ext_s = 1'b1; is_sw_s = 1'b1; end
      6'b000100: begin dec_op_s = 4'b0010; dec_ext_s = 1'b1; is_beq_s = 1'b1; end
      6'b000010: is_j_s = 1'b1;
      default:   legal_s = 1'b0;
    endcase
  end

  // Next-state logic and control outputs
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    PcWrite    = 1'b0;
    PcSrc      = 2'b00;
    IrWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    ExtSel     = 1'b0;
    Alu_SrcA   = 1'b0;
    Alu_SrcB   = 1'b0;
    Alu_Op     = 4'd0;
    illegal_op = 1'b0;
    state      = state_q;

    // Decoded ALU controls are held in every state after fetch
    if (state_q != S_IF) begin
      Alu_Op   = dec_op_s;
      Alu_SrcA = dec_srca_s;
      Alu_SrcB = dec_srcb_s;
      ExtSel   = dec_ext_s;
    end else begin
      Alu_Op   = 4'd0;
    end

    case (state_q)
      S_IF: begin
        IrWrite = 1'b1;
        PcWrite = 1'b1;
        ir_d    = instr;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_j_s) begin
          PcWrite = 1'b1;
          PcSrc   = 2'b10;
          state_d = S_IF;
        end else if (!legal_s) begin
          illegal_op = 1'b1;
          state_d    = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq_s) begin
          PcWrite = zero;
          PcSrc   = 2'b01;
          state_d = S_IF;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d    = 4'd0;
          MemWrite = is_sw_s;
          state_d  = is_sw_s ? S_IF : S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = is_lw_s;
        RegDst   = is_r_s;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset cycle: nothing may be enabled, even mid-instruction (e.g. sw in MEM)
    if (rst) begin
      PcWrite    = 1'b0;
      PcSrc      = 2'b00;
      IrWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      ExtSel     = 1'b0;
      Alu_SrcA   = 1'b0;
      Alu_SrcB   = 1'b0;
      Alu_Op     = 4'd0;
      illegal_op = 1'b0;
      state      = S_IF;
    end else begin
      state      = state_q;
    end
  end

  // State, IR and MEM wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int MW = 2;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       regw;
    logic       regdst;
    logic       memw;
    logic       m2r;
    logic       ext;
    logic       srca;
    logic       srcb;
    logic [3:0] aop;
    logic       ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        PcWrite, IrWrite, RegWrite, RegDst, MemWrite, MemToReg;
  logic        ExtSel, Alu_SrcA, Alu_SrcB, illegal_op;
  logic [1:0]  PcSrc;
  logic [3:0]  Alu_Op;
  logic [2:0]  state;

  out_t exp_q[$];
  out_t tmp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_ctrl #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .PcWrite(PcWrite), .PcSrc(PcSrc), .IrWrite(IrWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemWrite(MemWrite), .MemToReg(MemToReg), .ExtSel(ExtSel),
    .Alu_SrcA(Alu_SrcA), .Alu_SrcB(Alu_SrcB), .Alu_Op(Alu_Op), .state(state),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model: expected per-cycle control trace of one instruction into tmp_q
  function automatic void model(input logic [31:0] ins, input logic z);
    logic [5:0] op, fn;
    out_t f, c;
    bit r, lw, sw, beq, j, ok;
    op = ins[31:26];
    fn = ins[5:0];
    f = '0; r = 0; lw = 0; sw = 0; beq = 0; j = 0; ok = 1;
    if (op == 6'h00) begin
      r = 1;
      case (fn)
        6'h20, 6'h21: f.aop = 4'd1;
        6'h22, 6'h23: f.aop = 4'd2;
        6'h2A: f.aop = 4'd3;
        6'h24: f.aop = 4'd4;
        6'h27: f.aop = 4'd5;
        6'h25: f.aop = 4'd6;
        6'h26: f.aop = 4'd7;
        6'h00: begin f.aop = 4'd8; f.srca = 1'b1; end
        6'h02: begin f.aop = 4'd9; f.srca = 1'b1; end
        default: ok = 0;
      endcase
    end else begin
      case (op)
        6'h09: begin f.aop = 4'd1; f.ext = 1'b1; end
        6'h0A: begin f.aop = 4'd3; f.ext = 1'b1; end
        6'h0C: f.aop = 4'd4;
        6'h0D: f.aop = 4'd6;
        6'h0E: f.aop = 4'd7;
        6'h23: begin f.aop = 4'd1; f.ext = 1'b1; lw = 1; end
        6'h2B: begin f.aop = 4'd1; f.ext = 1'b1; sw = 1; end
        6'h04: begin f.aop = 4'd2; f.ext = 1'b1; beq = 1; end
        6'h02: j = 1;
        default: ok = 0;
      endcase
      f.srcb = (ok && !beq && !j);
    end
    tmp_q.delete();
    c = '0; c.pcw = 1'b1; c.irw = 1'b1;          // IF
    tmp_q.push_back(c);
    if (j) begin
      c = '0; c.st = 3'd1; c.pcw = 1'b1; c.pcsrc = 2'b10;
      tmp_q.push_back(c);
      return;
    end
    if (!ok) begin
      c = '0; c.st = 3'd1; c.ill = 1'b1;
      tmp_q.push_back(c);
      return;
    end
    c = f; c.st = 3'd1; tmp_q.push_back(c);      // ID
    c = f; c.st = 3'd2;                           // EXE
    if (beq) begin
      c.pcw = z; c.pcsrc = 2'b01;
      tmp_q.push_back(c);
      return;
    end
    tmp_q.push_back(c);
    if (lw || sw) begin
      for (int i = 0; i <= MW; i++) begin
        c = f; c.st = 3'd3; c.memw = sw && (i == MW);
        tmp_q.push_back(c);
      end
      if (sw) return;
    end
    c = f; c.st = 3'd4; c.regw = 1'b1; c.m2r = lw; c.regdst = r;
    tmp_q.push_back(c);
  endfunction

  // Monitor: compare DUT outputs against the next expected entry each cycle
  always @(negedge clk) begin
    out_t act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = '{st: state, pcw: PcWrite, pcsrc: PcSrc, irw: IrWrite, regw: RegWrite,
              regdst: RegDst, memw: MemWrite, m2r: MemToReg, ext: ExtSel,
              srca: Alu_SrcA, srcb: Alu_SrcB, aop: Alu_Op, ill: illegal_op};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL ctrl instr=%08h t=%0t got=%05h exp=%05h (st pcw pcsrc irw regw regdst memw m2r ext srca srcb aop ill)",
                 instr, $time, act, e);
      end
    end
  end

  // Issue one instruction from the IF cycle and wait for it to retire
  task automatic run_instr(input logic [31:0] ins, input logic z);
    int n;
    instr = ins;
    zero  = z;
    model(ins, z);
    n = tmp_q.size();
    foreach (tmp_q[k]) exp_q.push_back(tmp_q[k]);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0] ops [10] = '{6'h00, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] fns [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h24, 6'h27, 6'h25, 6'h26, 6'h00, 6'h02};
    w = $urandom;
    if ($urandom_range(0, 5) != 0) begin
      w[31:26] = ops[$urandom_range(0, 9)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 10)];
    end
    return w;
  endfunction

  initial begin
    out_t zv;
    zv = '0;
    rst = 1'b1; instr = 32'd0; zero = 1'b0;
    @(posedge clk); #1;
    repeat (3) exp_q.push_back(zv);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // directed: R-type ALU ops, shifts, immediate, branch, jump, memory, illegal
    run_instr(32'h00221821, 1'b0);
    run_instr(32'h00221823, 1'b0);
    run_instr(32'h0022182A, 1'b0);
    run_instr(32'h00221824, 1'b0);
    run_instr(32'h00221827, 1'b0);
    run_instr(32'h00221825, 1'b0);
    run_instr(32'h00221826, 1'b0);
    run_instr(32'h00021080, 1'b0);
    run_instr(32'h00021082, 1'b0);
    run_instr(32'h3421FFFF, 1'b0);
    run_instr(32'h10220003, 1'b1);
    run_instr(32'h10220003, 1'b0);
    run_instr(32'h08000010, 1'b0);
    run_instr(32'h8C220004, 1'b0);
    run_instr(32'hAC220004, 1'b0);
    run_instr(32'hFC000000, 1'b0);

    // reset in the second MEM cycle of sw: no write, back to IF
    instr = 32'hAC220004;
    model(instr, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back(tmp_q[k]);
    exp_q.push_back(zv);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(32'h00221821, 1'b0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) run_instr(rand_instr(), 1'($urandom_range(0, 1)));

    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit that drives the existing ALU's control inputs: Alu_Op[3:0], Alu_SrcA and Alu_SrcB.
- Also drives the PC, IR, register-file and data-memory write enables.
- Latches the fetched instruction, decodes opcode/funct, and sequences IF→ID→EXE→MEM→WB.
- Consumes the ALU zero flag for beq; replaces per-instruction combinational control when the datapath moves from single-cycle to multi-cycle.

Parameters:
- MEM_WAIT, 0, extra wait cycles spent in MEM before the access completes (0..15); models slow data memory.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  instruction-memory read data; valid during IF.
- zero  input  1  ALU zero flag; sampled in EXE.
- PcWrite  output  1  PC register load enable.
- PcSrc  output  2  00 = PC+4, 01 = branch target, 10 = jump target.
- IrWrite  output  1  datapath IR load enable.
- RegWrite  output  1  register-file write enable.
- RegDst  output  1  1 = rd, 0 = rt.
- MemWrite  output  1  data-memory write enable.
- MemToReg  output  1  1 = writeback from memory, 0 = from ALU.
- ExtSel  output  1  1 = sign-extend imm16, 0 = zero-extend.
- Alu_SrcA  output  1  1 = shamt, 0 = ReadData1.
- Alu_SrcB  output  1  1 = extended immediate, 0 = ReadData2.
- Alu_Op  output  4  ALU operation code.
- state  output  3  current state, for debug.
- illegal_op  output  1  one-cycle pulse in ID on an unsupported opcode/funct.

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Internal ir[31:0] latches instr on the clk edge leaving IF. Outputs are combinational from state and ir.
- Reset (synchronous, sampled at a clk edge, also valid mid-instruction):
  - state=IF, ir=0, wait counter=0.
  - In the reset cycle all enables, PcSrc and Alu_Op are 0 and illegal_op=0.
  - A reset in MEM during sw must leave MemWrite at 0.
- IF: IrWrite=1, PcWrite=1, PcSrc=00. Next state ID.
- ID: decode ir. Next state:
  - j (op 000010): PcWrite=1, PcSrc=10, next IF.
  - Unsupported op/funct: illegal_op=1, next IF, no writes.
  - Otherwise: next EXE.
- Alu_Op and source decode:
  - Alu_Op encoding: 0001 add, 0010 sub, 0011 slt, 0100 and, 0101 nor, 0110 or, 0111 xor, 1000 sll, 1001 srl.
  - R-type (op 000000), funct→Alu_Op: 100000/100001→0001, 100010/100011→0010, 101010→0011, 100100→0100, 100111→0101, 100101→0110, 100110→0111, 000000→1000, 000010→1001.
  - sll/srl set Alu_SrcA=1; all other R-type use Alu_SrcA=0. R-type: Alu_SrcB=0, RegDst=1.
  - I-type, op→Alu_Op, Alu_SrcB=1:
    - addiu 001001→0001, ExtSel=1.
    - slti 001010→0011, ExtSel=1.
    - andi 001100→0100, ExtSel=0.
    - ori 001101→0110, ExtSel=0.
    - xori 001110→0111, ExtSel=0.
    - lw 100011 / sw 101011→0001, ExtSel=1.
  - beq 000100: Alu_Op=0010, Alu_SrcB=0, ExtSel=1.
  - Alu_Op/SrcA/SrcB/ExtSel hold their decoded values throughout ID, EXE, MEM and WB. In IF they are 0.
- EXE:
  - beq: PcWrite=zero, PcSrc=01, next IF.
  - lw/sw: next MEM.
  - ALU ops: next WB.
- MEM:
  - Counter counts 0..MEM_WAIT and the state stays MEM until count==MEM_WAIT; total MEM cycles = MEM_WAIT+1.
  - sw: MemWrite=1 only on the final MEM cycle, then next IF.
  - lw: next WB. Counter clears on exit.
- WB: RegWrite=1, single cycle.
  - MemToReg=1 for lw, 0 otherwise. RegDst=0 for I-type.
  - Next IF.
- CPI: j=2, beq=3, ALU=4, sw=4+MEM_WAIT, lw=5+MEM_WAIT, illegal=2.
- At most one of {RegWrite, MemWrite} is high in any cycle. IrWrite is high only in IF.

Test Plan:
- Reset then hold rst=1 for 3 cycles → state=0, all enables 0, Alu_Op=0000. Release → IrWrite=1 and PcWrite=1 on the first cycle.
- Feed addu (0x00221821), subu, slt, and, nor, or, xor in turn → Alu_Op=0001/0010/0011/0100/0101/0110/0111 in EXE, Alu_SrcA=0, Alu_SrcB=0. RegWrite=1 and RegDst=1 in WB, 4 cycles each.
- sll (0x00021080) and srl (0x00021082) → Alu_Op=1000/1001, Alu_SrcA=1. ori 0x3421FFFF → Alu_Op=0110, Alu_SrcB=1, ExtSel=0, RegDst=0.
- beq 0x10220003 with zero=1 → PcWrite=1 and PcSrc=01 in EXE. With zero=0 → PcWrite=0. Both return to IF after 3 cycles. j 0x08000010 → PcSrc=10 in ID, 2 cycles.
- MEM_WAIT=2: lw 0x8C220004 → 3 MEM cycles, then WB with MemToReg=1, 7 cycles total. sw 0xAC220004 → MemWrite high only on the 3rd MEM cycle. Assert rst in MEM cycle 2 of sw → MemWrite never rises and state=IF.
- Opcode 0x3F (0xFC000000) → illegal_op pulses exactly 1 cycle in ID, no write enables, next state IF.
